hazard_unit: RTL and testbench
==============================

Name: hazard_unit

Overview:
Hazard detection and forwarding control for the 5-stage (IF/DE/EX/MEM/WB) RV32 core pipeline. It resolves RAW hazards by selecting EX-stage operand bypass sources from MEM or WB. It stalls IF/DE on load-use dependencies and flushes DE/EX on taken branches and jumps. Its outputs drive the pipeline-register enable/clear inputs and the EX operand muxes.

Parameters:
REG_ADDR_W, 5, register-file index width (x0..x31)

Ports:
clk  in  1  core clock
reset  in  1  synchronous active-high reset
de_rs1  in  REG_ADDR_W  rs1 index of instruction in DE
de_rs2  in  REG_ADDR_W  rs2 index of instruction in DE
ex_rs1  in  REG_ADDR_W  rs1 index of instruction in EX
ex_rs2  in  REG_ADDR_W  rs2 index of instruction in EX
ex_rd  in  REG_ADDR_W  rd index of instruction in EX
ex_pc_src  in  1  1 = branch taken / jump resolved in EX
ex_result_src  in  2  result select of EX instruction (00 ALU, 01 memory load, 10 PC+4, 11 reserved)
mem_rd  in  REG_ADDR_W  rd index in MEM
mem_reg_write  in  1  MEM instruction writes rd
wb_rd  in  REG_ADDR_W  rd index in WB
wb_reg_write  in  1  WB instruction writes rd
if_stall  out  1  hold PC / IF-DE register
de_stall  out  1  hold DE-EX inputs (DE stage)
de_flush  out  1  clear IF/DE pipeline register (bubble into DE)
ex_flush  out  1  clear DE/EX pipeline register (bubble into EX)
ex_op1_forward  out  2  EX operand-1 source: 00 register file, 01 WB result, 10 MEM ALU result
ex_op2_forward  out  2  same encoding for operand 2

Behaviour:
- Forwarding is purely combinational, with zero latency.
- op1: 10 if mem_reg_write && mem_rd==ex_rs1 && ex_rs1!=0.
- op1 otherwise: 01 if wb_reg_write && wb_rd==ex_rs1 && ex_rs1!=0.
- op1 otherwise: 00.
- MEM has priority over WB when both match (newest value wins).
- op2 uses the same rules with ex_rs2.
- x0 is never forwarded. A matching rd with reg_write=0 is never forwarded.
- Encoding 11 is never produced.
- Load-use: lw_stall = (ex_result_src==01) && ex_rd!=0 && (de_rs1==ex_rd || de_rs2==ex_rd).
- if_stall = de_stall = lw_stall.
- de_flush = ex_pc_src.
- ex_flush = lw_stall | ex_pc_src.
- Load followed by taken branch in EX: both stall and flush are asserted; the flush wins in the pipeline-register priority.
- The unit does not suppress stalls for branches; stall and flush are independent signals.
- Reset/start-up: one internal register init_q.
  - init_q <= 1 on any clk edge where reset=1.
  - init_q <= 0 on the next edge with reset=0.
  - While reset=1 or init_q=1: de_flush=ex_flush=1, if_stall=de_stall=0, both forwards=00, overriding all hazard logic.
  - This guarantees the pipeline comes out of reset with DE/EX bubbles for one cycle after reset deasserts.
- Reset asserted mid-operation: flush override applies combinationally in that same cycle.
- Reset effects on init_q take place at the next edge (synchronous).
- All outputs are defined (no X) whenever inputs are known.
- Outside the reset/start-up window, outputs depend only on the current inputs (no other state).

Decomposition:
- Shared package core_pkg holds:
  - REG_ADDR_W
  - result_src enum (RES_ALU=00, RES_MEM=01, RES_PC4=10)
  - forward_sel enum (FWD_RF=00, FWD_WB=01, FWD_MEM=10)
- One natural sub-module: forward_sel_unit, a single-operand compare/priority block instantiated twice (ex_rs1, ex_rs2).
- Stall/flush logic and init_q stay in the top.

Test Plan:
- Quiet start (5 cycles reset, then release), all inputs 0 -> first cycle after release: flushes=1, stalls=0, fwd=00. Following cycle: flushes=0, stalls=0, fwd=00.
- MEM forward: ex_rs1=2, mem_rd=2, mem_reg_write=1 -> ex_op1_forward=10, ex_op2_forward=00. Same with mem_reg_write=0 -> 00. ex_rs1=0, mem_rd=0, mem_reg_write=1 -> 00.
- WB forward and priority: ex_rs2=3, wb_rd=3, wb_reg_write=1 -> ex_op2_forward=01. Adding mem_rd=3, mem_reg_write=1 -> 10. ex_rs1=2, ex_rs2=3 matching MEM and WB respectively -> 10/01.
- Load-use: ex_result_src=01, ex_rd=2, de_rs1=2 -> if_stall=de_stall=ex_flush=1, de_flush=0. Same with ex_result_src=00 -> all 0. ex_rd=0, de_rs2=0 -> no stall.
- Control hazard: ex_pc_src=1, others 0 -> de_flush=ex_flush=1, stalls 0. Combined with the load-use condition -> if_stall=de_stall=1, de_flush=ex_flush=1.
- Mid-run reset: during the active MEM-forward case, assert reset for 1 cycle -> fwd=00 and flushes=1 immediately. After release, the override holds for one more cycle, then forwarding resumes.

Source files
------------

// File: rtl/core_pkg.sv
// Shared core definitions: register index width and the encodings used by the
// hazard unit for result selection and EX operand bypass selection.
package core_pkg;

    localparam int unsigned REG_ADDR_W = 5;

    typedef enum logic [1:0] {
        RES_ALU = 2'b00,
        RES_MEM = 2'b01,
        RES_PC4 = 2'b10
    } result_src_e;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } forward_sel_e;

endpackage

// File: rtl/forward_sel_unit.sv
// Bypass source selection for one EX operand. MEM holds the newer value, so it
// wins over WB; x0 and non-writing producers are never bypassed.
module forward_sel_unit
    import core_pkg::*;
(
    input  logic [REG_ADDR_W-1:0] rs,
    input  logic [REG_ADDR_W-1:0] mem_rd,
    input  logic                  mem_reg_write,
    input  logic [REG_ADDR_W-1:0] wb_rd,
    input  logic                  wb_reg_write,
    output logic [1:0]            fwd_sel
);

    logic rs_nonzero;

    assign rs_nonzero = (rs != '0);

    // Priority compare: MEM first, then WB, else register file.
    always_comb begin
        fwd_sel = FWD_RF;
        if (mem_reg_write && (mem_rd == rs) && rs_nonzero) begin
            fwd_sel = FWD_MEM;
        end else if (wb_reg_write && (wb_rd == rs) && rs_nonzero) begin
            fwd_sel = FWD_WB;
        end
    end

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard unit: EX operand bypass selection, load-use stall and
// branch/jump flush. A start-up window (reset, plus one cycle after release)
// forces bubbles into DE and EX and suppresses stalls and bypassing.
module hazard_unit
    import core_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic [REG_ADDR_W-1:0] de_rs1,
    input  logic [REG_ADDR_W-1:0] de_rs2,
    input  logic [REG_ADDR_W-1:0] ex_rs1,
    input  logic [REG_ADDR_W-1:0] ex_rs2,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  ex_pc_src,
    input  logic [1:0]            ex_result_src,
    input  logic [REG_ADDR_W-1:0] mem_rd,
    input  logic                  mem_reg_write,
    input  logic [REG_ADDR_W-1:0] wb_rd,
    input  logic                  wb_reg_write,
    output logic                  if_stall,
    output logic                  de_stall,
    output logic                  de_flush,
    output logic                  ex_flush,
    output logic [1:0]            ex_op1_forward,
    output logic [1:0]            ex_op2_forward
);

    logic       init_d;
    logic       init_q;
    logic       lw_stall;
    logic       start_window;
    logic [1:0] op1_sel;
    logic [1:0] op2_sel;

    forward_sel_unit u_fwd_op1 (
        .rs            (ex_rs1),
        .mem_rd        (mem_rd),
        .mem_reg_write (mem_reg_write),
        .wb_rd         (wb_rd),
        .wb_reg_write  (wb_reg_write),
        .fwd_sel       (op1_sel)
    );

    forward_sel_unit u_fwd_op2 (
        .rs            (ex_rs2),
        .mem_rd        (mem_rd),
        .mem_reg_write (mem_reg_write),
        .wb_rd         (wb_rd),
        .wb_reg_write  (wb_reg_write),
        .fwd_sel       (op2_sel)
    );

    // init_q is set by every reset edge and cleared by the first edge without reset.
    always_comb begin
        init_d = reset;
    end

    // Start-up flag register (synchronous reset).
    always_ff @(posedge clk) begin
        if (reset) begin
            init_q <= 1'b1;
        end else begin
            init_q <= init_d;
        end
    end

    assign start_window = reset | init_q;

    // Load in EX whose destination is read by the instruction in DE.
    always_comb begin
        lw_stall = (ex_result_src == RES_MEM) && (ex_rd != '0) &&
                   ((de_rs1 == ex_rd) || (de_rs2 == ex_rd));
    end

    // Output decode; the start-up window overrides all hazard logic.
    always_comb begin
        if_stall       = lw_stall;
        de_stall       = lw_stall;
        de_flush       = ex_pc_src;
        ex_flush       = lw_stall | ex_pc_src;
        ex_op1_forward = op1_sel;
        ex_op2_forward = op2_sel;
        if (start_window) begin
            if_stall       = 1'b0;
            de_stall       = 1'b0;
            de_flush       = 1'b1;
            ex_flush       = 1'b1;
            ex_op1_forward = FWD_RF;
            ex_op2_forward = FWD_RF;
        end
    end

endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit: directed cases followed by randomized
// stimulus, all compared against a behavioural model of the hazard rules.
module tb_hazard_unit;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] de_rs1, de_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
    logic       ex_pc_src, mem_reg_write, wb_reg_write;
    logic [1:0] ex_result_src;
    logic       if_stall, de_stall, de_flush, ex_flush;
    logic [1:0] ex_op1_forward, ex_op2_forward;

    int n_tests = 0;
    int n_fail  = 0;

    // Reset value seen at the most recent rising edge.
    bit rst_at_last_edge = 1'b0;

    always #5 clk = ~clk;

    always @(posedge clk) rst_at_last_edge <= reset;

    hazard_unit dut (
        .clk            (clk),
        .reset          (reset),
        .de_rs1         (de_rs1),
        .de_rs2         (de_rs2),
        .ex_rs1         (ex_rs1),
        .ex_rs2         (ex_rs2),
        .ex_rd          (ex_rd),
        .ex_pc_src      (ex_pc_src),
        .ex_result_src  (ex_result_src),
        .mem_rd         (mem_rd),
        .mem_reg_write  (mem_reg_write),
        .wb_rd          (wb_rd),
        .wb_reg_write   (wb_reg_write),
        .if_stall       (if_stall),
        .de_stall       (de_stall),
        .de_flush       (de_flush),
        .ex_flush       (ex_flush),
        .ex_op1_forward (ex_op1_forward),
        .ex_op2_forward (ex_op2_forward)
    );

    task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b (stall_if,stall_de,flush_de,flush_ex,op1,op2)",
                     tag, got, exp);
        end
    endtask

    // Bypass source for one operand: newest producer of a nonzero register.
    function automatic logic [1:0] model_fwd(input logic [4:0] rs);
        if (rs == 0) return 2'd0;
        if (mem_reg_write && mem_rd == rs) return 2'd2;
        if (wb_reg_write && wb_rd == rs) return 2'd1;
        return 2'd0;
    endfunction

    function automatic logic [7:0] model_out();
        logic lw;
        logic br;
        if (reset || rst_at_last_edge) return 8'b0011_0000;
        lw = (ex_result_src == 2'd1) && (ex_rd != 0) && (de_rs1 == ex_rd || de_rs2 == ex_rd);
        br = ex_pc_src;
        return {lw, lw, br, lw | br, model_fwd(ex_rs1), model_fwd(ex_rs2)};
    endfunction

    task automatic clear_inputs();
        de_rs1 = 0; de_rs2 = 0; ex_rs1 = 0; ex_rs2 = 0; ex_rd = 0;
        mem_rd = 0; wb_rd = 0; ex_pc_src = 0; mem_reg_write = 0;
        wb_reg_write = 0; ex_result_src = 0;
    endtask

    // Sample on the falling edge, then advance to just after the next rising edge.
    task automatic cycle_check(input string tag);
        @(negedge clk);
        check_eq(tag, {if_stall, de_stall, de_flush, ex_flush, ex_op1_forward, ex_op2_forward},
                 model_out());
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        clear_inputs();
        for (int i = 0; i < 5; i++) cycle_check("reset_hold");
        reset = 1'b0;
        cycle_check("startup_bubble");
        cycle_check("quiet_run");

        ex_rs1 = 2; mem_rd = 2; mem_reg_write = 1;
        cycle_check("mem_fwd_op1");
        mem_reg_write = 0;
        cycle_check("mem_no_write");
        ex_rs1 = 0; mem_rd = 0; mem_reg_write = 1;
        cycle_check("mem_x0");

        clear_inputs();
        ex_rs2 = 3; wb_rd = 3; wb_reg_write = 1;
        cycle_check("wb_fwd_op2");
        mem_rd = 3; mem_reg_write = 1;
        cycle_check("mem_over_wb");
        ex_rs1 = 2; mem_rd = 2;
        cycle_check("split_mem_wb");

        clear_inputs();
        ex_result_src = 2'd1; ex_rd = 2; de_rs1 = 2;
        cycle_check("load_use");
        ex_result_src = 2'd0;
        cycle_check("alu_no_stall");
        ex_result_src = 2'd1; ex_rd = 0; de_rs1 = 0; de_rs2 = 0;
        cycle_check("load_x0");

        clear_inputs();
        ex_pc_src = 1;
        cycle_check("branch_flush");
        ex_result_src = 2'd1; ex_rd = 5; de_rs2 = 5;
        cycle_check("load_and_branch");

        clear_inputs();
        ex_rs1 = 2; mem_rd = 2; mem_reg_write = 1;
        cycle_check("pre_reset_fwd");
        reset = 1'b1;
        cycle_check("midrun_reset");
        reset = 1'b0;
        cycle_check("midrun_release");
        cycle_check("midrun_resume");

        for (int i = 0; i < 400; i++) begin
            de_rs1        = 5'($urandom_range(0, 3));
            de_rs2        = 5'($urandom_range(0, 3));
            ex_rs1        = 5'($urandom_range(0, 3));
            ex_rs2        = 5'($urandom_range(0, 3));
            ex_rd         = 5'($urandom_range(0, 3));
            mem_rd        = 5'($urandom_range(0, 3));
            wb_rd         = 5'($urandom_range(0, 3));
            ex_pc_src     = ($urandom_range(0, 3) == 0);
            mem_reg_write = 1'($urandom);
            wb_reg_write  = 1'($urandom);
            ex_result_src = 2'($urandom);
            reset         = ($urandom_range(0, 24) == 0);
            cycle_check("random");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
